// File: rtl/dht_onewire_reader.sv
// dht_onewire_reader: host-side single-wire engine for DHT11-class sensors.
// Issues the start pulse, decodes the 40-bit frame MSB first and presents
// hum/humd/tem/temd/sum with a one-cycle done strobe.
// Optional: define DHT_CHECKSUM_EN so that only checksum-valid frames update
// the data bytes and a mismatch reports error.
module dht_onewire_reader #(
  parameter int CYCLES_PER_US = 50,
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 255,
  parameter int BIT_THRESH_US = 40
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        onewire,
  input  logic       measure,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] hum,
  output logic [7:0] humd,
  output logic [7:0] tem,
  output logic [7:0] temd,
  output logic [7:0] sum
);

  localparam int PW = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(CYCLES_PER_US - 1);
  localparam logic [15:0]   START_CNT = 16'(START_LOW_US);
  localparam logic [15:0]   TMO_CNT   = 16'(TIMEOUT_US);
  localparam logic [15:0]   THR_CNT   = 16'(BIT_THRESH_US);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_WAIT_ACK = 3'd2;
  localparam logic [2:0] S_ACK_LOW  = 3'd3;
  localparam logic [2:0] S_ACK_HIGH = 3'd4;
  localparam logic [2:0] S_BIT_LOW  = 3'd5;
  localparam logic [2:0] S_BIT_HIGH = 3'd6;
  localparam logic [2:0] S_FINISH   = 3'd7;

  logic [2:0]    state, state_nxt;
  logic [2:0]    sync;
  logic          ow_s, ow_p, rise, fall;
  logic [PW-1:0] pre;
  logic          us_tick;
  logic [15:0]   us_cnt, us_nxt;
  logic [5:0]    bit_idx;
  logic [39:0]   shreg;
  logic          tmo, shift_en, abort, bit_val;
  logic [7:0]    csum;
  logic          csum_ok;

  // Open-drain: only ever pull low, otherwise leave the line to the pull-up.
  assign onewire = (state == S_START) ? 1'b0 : 1'bz;

  // Two-FF synchronizer plus one history stage for edge detection; idles high.
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync <= 3'b111;
    else        sync <= {sync[1:0], onewire};

  assign ow_s = sync[1];
  assign ow_p = sync[2];
  assign rise = ow_s & ~ow_p;
  assign fall = ~ow_s & ow_p;

  assign us_tick = (pre == PRE_MAX);
  // Count including the tick of the current cycle, so a pulse of N us
  // measures exactly N at its closing edge.
  assign us_nxt  = (us_tick && us_cnt != 16'hFFFF) ? us_cnt + 16'd1 : us_cnt;
  assign tmo     = (us_cnt >= TMO_CNT);
  assign bit_val = (us_nxt > THR_CNT);

  assign csum    = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
  assign csum_ok = (csum == shreg[7:0]);

  // Next-state decode; timeouts take priority over edges in sensor phases.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE:     if (measure) state_nxt = S_START;
      S_START:    if (us_nxt >= START_CNT) state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (tmo) abort = 1'b1; else if (fall) state_nxt = S_ACK_LOW;
      S_ACK_LOW:  if (tmo) abort = 1'b1; else if (rise) state_nxt = S_ACK_HIGH;
      S_ACK_HIGH: if (tmo) abort = 1'b1; else if (fall) state_nxt = S_BIT_LOW;
      S_BIT_LOW:  if (tmo) abort = 1'b1; else if (rise) state_nxt = S_BIT_HIGH;
      S_BIT_HIGH: begin
        if (tmo) abort = 1'b1;
        else if (fall) begin
          shift_en  = 1'b1;
          state_nxt = (bit_idx == 6'd39) ? S_FINISH : S_BIT_LOW;
        end
      end
      S_FINISH:   state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  // Microsecond prescaler and saturating phase counter, restarted per state.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pre    <= '0;
      us_cnt <= '0;
    end else if (state_nxt != state) begin
      pre    <= '0;
      us_cnt <= '0;
    end else begin
      pre    <= us_tick ? '0 : pre + PW'(1);
      us_cnt <= us_nxt;
    end

  // FSM state, frame shift register, status flags and output bytes.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      error   <= 1'b0;
      bit_idx <= '0;
      shreg   <= '0;
      hum     <= '0;
      humd    <= '0;
      tem     <= '0;
      temd    <= '0;
      sum     <= '0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      if (state == S_IDLE && measure) begin
        busy  <= 1'b1;
        error <= 1'b0;
      end
      if (state == S_ACK_HIGH && state_nxt == S_BIT_LOW) bit_idx <= '0;
      if (shift_en) begin
        shreg   <= {shreg[38:0], bit_val};
        bit_idx <= bit_idx + 6'd1;
      end
      if (abort) begin
        done  <= 1'b1;
        busy  <= 1'b0;
        error <= 1'b1;
      end
      if (state == S_FINISH) begin
        done <= 1'b1;
        busy <= 1'b0;
`ifdef DHT_CHECKSUM_EN
        error <= ~csum_ok;
        if (csum_ok) begin
          hum  <= shreg[39:32];
          humd <= shreg[31:24];
          tem  <= shreg[23:16];
          temd <= shreg[15:8];
          sum  <= shreg[7:0];
        end
`else
        error <= 1'b0;
        hum   <= shreg[39:32];
        humd  <= shreg[31:24];
        tem   <= shreg[23:16];
        temd  <= shreg[15:8];
        sum   <= shreg[7:0];
`endif
      end
    end

endmodule

// File: tb/tb_dht_onewire_reader.sv
// Bench for dht_onewire_reader: sensor model on the open-drain line, table of
// fixed frames, random frames against a width-based reference model, and
// hand sequences for timeout, measure-while-busy and mid-frame reset.
module tb_dht_onewire_reader;
  localparam int CPU = 2;
  localparam int SLU = 20;
  localparam int TMO = 255;
  localparam int THR = 40;

  logic clk = 1'b0, reset = 1'b0, measure = 1'b0, sens_low = 1'b0;
  wire  onewire;
  logic busy, done, error;
  logic [7:0] hum, humd, tem, temd, sum;

  assign onewire = sens_low ? 1'b0 : 1'bz;
  pullup (onewire);

  always #5 clk = ~clk;

  dht_onewire_reader #(.CYCLES_PER_US(CPU), .START_LOW_US(SLU),
                       .TIMEOUT_US(TMO), .BIT_THRESH_US(THR)) dut (
    .clk(clk), .reset(reset), .onewire(onewire), .measure(measure),
    .busy(busy), .done(done), .error(error),
    .hum(hum), .humd(humd), .tem(tem), .temd(temd), .sum(sum));

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, viol = 0;
  logic done_prev = 1'b0;
  int wid [40];
  logic [39:0] exp_d = '0;
  logic exp_err = 1'b0;

  typedef struct {
    logic [39:0] frm;
    int          z_us;
    int          o_us;
    logic [39:0] exp;
    logic        err;
  } vec_t;
  vec_t tv [3];

  always @(posedge clk) cyc <= cyc + 1;

  // done must be a single-cycle pulse and never overlap busy
  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (done && (busy || done_prev)) viol <= viol + 1;
    done_prev <= done;
  end

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_us(input int n);
    repeat (n * CPU) @(negedge clk);
  endtask

  task automatic pulse_measure();
    @(negedge clk) measure = 1'b1;
    @(negedge clk) measure = 1'b0;
  endtask

  // Wait for the host start pulse and return its length in cycles.
  task automatic host_start(output int low_cyc);
    int g;
    g = 0;
    while (onewire !== 1'b0 && g < 100) begin @(negedge clk); g++; end
    low_cyc = 0;
    while (onewire === 1'b0 && low_cyc < 1000) begin low_cyc++; @(negedge clk); end
  endtask

  // Sensor: ack, then 40 bits of 20 us low + wid[i] us high, then a tail low.
  task automatic sensor(input int poke_bit, input int rst_bit, output int low_cyc);
    host_start(low_cyc);
    wait_us(10);
    sens_low = 1'b1; wait_us(40);
    sens_low = 1'b0; wait_us(40);
    for (int i = 0; i < 40; i++) begin
      sens_low = 1'b1; wait_us(20);
      sens_low = 1'b0;
      if (i == rst_bit) begin
        wait_us(10);
        reset = 1'b0;
        return;
      end
      if (i == poke_bit) begin
        repeat (10) @(negedge clk);
        measure = 1'b1;
        @(negedge clk);
        measure = 1'b0;
        repeat (wid[i] * CPU - 11) @(negedge clk);
      end else begin
        wait_us(wid[i]);
      end
    end
    sens_low = 1'b1; wait_us(20);
    sens_low = 1'b0;
  endtask

  task automatic set_widths(input logic [39:0] frm, input int z, input int o);
    for (int i = 0; i < 40; i++) wid[i] = frm[39-i] ? o : z;
  endtask

  task automatic rand_widths(input logic [39:0] frm);
    for (int i = 0; i < 40; i++)
      wid[i] = frm[39-i] ? int'($urandom_range(60, 41)) : int'($urandom_range(40, 12));
  endtask

  // Reference: bit is 1 iff its high pulse exceeds the threshold.
  task automatic model_frame();
    logic [39:0] bits;
    logic [7:0]  cs;
    for (int i = 0; i < 40; i++) bits[39-i] = (wid[i] > THR);
    cs = bits[39:32] + bits[31:24] + bits[23:16] + bits[15:8];
`ifdef DHT_CHECKSUM_EN
    if (cs == bits[7:0]) begin exp_d = bits; exp_err = 1'b0; end
    else exp_err = 1'b1;
`else
    if (cs == 8'h00 || cs != 8'h00) begin exp_d = bits; exp_err = 1'b0; end
`endif
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".hum"},   {32'd0, hum},  {32'd0, exp_d[39:32]});
    chk({tag, ".humd"},  {32'd0, humd}, {32'd0, exp_d[31:24]});
    chk({tag, ".tem"},   {32'd0, tem},  {32'd0, exp_d[23:16]});
    chk({tag, ".temd"},  {32'd0, temd}, {32'd0, exp_d[15:8]});
    chk({tag, ".sum"},   {32'd0, sum},  {32'd0, exp_d[7:0]});
    chk({tag, ".error"}, {39'd0, error}, {39'd0, exp_err});
    chk({tag, ".busy"},  {39'd0, busy}, 40'd0);
  endtask

  task automatic run_frame(input string tag, input int poke);
    int d0, low, n;
    d0 = done_cnt;
    pulse_measure();
    sensor(poke, -1, low);
    n = 0;
    while (done_cnt == d0 && n < 200) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    chk({tag, ".start_low"}, 40'(low), 40'(SLU * CPU));
    chk({tag, ".done_cnt"}, 40'(done_cnt - d0), 40'd1);
    chk_outs(tag);
  endtask

  initial begin
    int d0, low, n, dly;
    logic [39:0] f;
    logic [7:0]  cs;

    tv[0] = '{40'h3700190050, 26, 70, 40'h3700190050, 1'b0};
`ifdef DHT_CHECKSUM_EN
    tv[1] = '{40'h3700190051, 26, 70, 40'h3700190050, 1'b1};
`else
    tv[1] = '{40'h3700190051, 26, 70, 40'h3700190051, 1'b0};
`endif
    tv[2] = '{40'hA53C0FF0E0, 40, 41, 40'hA53C0FF0E0, 1'b0};

    // reset state
    repeat (5) @(negedge clk);
    chk_outs("reset");
    chk("reset.done", {39'd0, done}, 40'd0);
    chk("reset.line", {39'd0, onewire}, 40'd1);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    // fixed frames, including checksum mismatch and 40/41 us boundary
    for (int k = 0; k < 3; k++) begin
      set_widths(tv[k].frm, tv[k].z_us, tv[k].o_us);
      exp_d   = tv[k].exp;
      exp_err = tv[k].err;
      run_frame($sformatf("vec%0d", k), -1);
    end

    // sensor never answers
    d0 = done_cnt;
    pulse_measure();
    host_start(low);
    dly = cyc;
    n = 0;
    while (done_cnt == d0 && n < 700 * CPU) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("tmo.done_cnt", 40'(done_cnt - d0), 40'd1);
    dly = done_cyc - dly;
    chk("tmo.delay_ok", {39'd0, (dly >= TMO * CPU - 2 && dly <= TMO * CPU + 4)}, 40'd1);
    exp_err = 1'b1;
    chk_outs("tmo");

    // measure during bit 10 is dropped
    set_widths(40'h12345678BE, 26, 70);
    model_frame();
    run_frame("poke", 10);

    // random frames, half with a valid checksum
    for (int r = 0; r < 5; r++) begin
      f[39:8] = $urandom;
      cs = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      f[7:0] = $urandom_range(1, 0) ? cs : 8'($urandom);
      rand_widths(f);
      model_frame();
      run_frame($sformatf("rnd%0d", r), -1);
    end

    // reset during BIT_HIGH of bit 12
    f = 40'h5A5A5A5A10;
    rand_widths(f);
    pulse_measure();
    sensor(-1, 12, low);
    #1;
    exp_d   = '0;
    exp_err = 1'b0;
    chk_outs("midrst");
    chk("midrst.done", {39'd0, done}, 40'd0);
    chk("midrst.line", {39'd0, onewire}, 40'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    rand_widths(f);
    model_frame();
    run_frame("postrst", -1);

    chk("done_protocol", 40'(viol), 40'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dht_onewire_reader.md
# dht_onewire_reader

Single-wire protocol engine for the DHT11-class humidity/temperature sensor. It sits between the sensor pin and the Wishbone serial peripheral. On a one-cycle `measure` request it runs the host start sequence and decodes the 40-bit sensor frame. It then presents humidity, temperature and checksum bytes to the bus-side register file with a one-cycle `done` strobe.

## Interface
- `CYCLES_PER_US`, 50: clk cycles per microsecond; sets the prescaler.
- `START_LOW_US`, 18000: duration the host drives the line low to request a frame.
- `TIMEOUT_US`, 255: maximum duration of any sensor-driven phase before abort.
- `BIT_THRESH_US`, 40: data high-pulse length above which the bit is 1.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `onewire`  inout  1  open-drain sensor line; driven 0 or released to Z, with an external pull-up.
- `measure`  in  1  one-cycle start request; ignored while `busy`=1.
- `busy`  out  1  high from the accepted `measure` until `done`.
- `done`  out  1  one-cycle pulse at the end of a frame (success or error).
- `error`  out  1  status of the last frame; 1 = timeout or checksum fail; held until the next accepted `measure`.
- `hum`, `humd`, `tem`, `temd`, `sum`  out  8 each  last captured frame bytes.

## Operation
- `onewire` input passes through a 2-FF synchronizer; all edge detection uses the synchronized value.
- A prescaler produces `us_tick` every `CYCLES_PER_US` cycles. It is cleared on every state change. The phase counter `us_cnt` (16 bits) counts ticks and saturates.
- FSM states:
  - **IDLE**: line released. `measure` → START; clear `error`, set `busy`.
  - **START**: drive 0 for `START_LOW_US`, then release → WAIT_ACK.
  - **WAIT_ACK**: wait for a synchronized falling edge → ACK_LOW.
  - **ACK_LOW**: wait for a rising edge → ACK_HIGH.
  - **ACK_HIGH**: wait for a falling edge → BIT_LOW; bit index = 0.
  - **BIT_LOW**: wait for a rising edge → BIT_HIGH.
  - **BIT_HIGH**: on a falling edge, shift in bit = (`us_cnt` > `BIT_THRESH_US`), MSB first into a 40-bit register. Go to BIT_LOW, or to FINISH after bit 39.
  - **FINISH**: one cycle. Load outputs, pulse `done`, clear `busy` → IDLE.
- Frame byte order, first received first: `hum`, `humd`, `tem`, `temd`, `sum`.
- Checksum = 8-bit truncated sum of the first four bytes, compared against `sum`.
- Timeout: in any of WAIT_ACK through BIT_HIGH, `us_cnt` reaching `TIMEOUT_US` aborts the frame. `error` is set to 1, `done` pulses, the line is released and the FSM returns to IDLE. Data outputs keep their previous values.
- `measure` while `busy` is dropped, not queued.
- Reset (any time, including mid-frame): line released immediately. FSM goes to IDLE and all outputs clear to 0, including `busy`, `done`, `error` and all data bytes.

## Timing
- Accepted `measure` at cycle N: the FSM is in START and the line is driven low at cycle N+1.
- Synchronizer latency: 2 cycles from pin to FSM edge detect. Pulse-width measurement is unaffected because both edges incur the same delay.
- Final falling edge of bit 39 seen at cycle M: FINISH at M+1, with outputs and `done` valid at M+2. `busy` falls in the same cycle that `done` rises.
- Bit decision resolution is 1 µs; `us_cnt` = `BIT_THRESH_US` exactly decodes as 0.
- `done` is never asserted for more than one cycle. `done` and `busy` are never both 1.

## Configuration
- `DHT_CHECKSUM_EN` defined: a checksum mismatch sets `error`=1 and data outputs keep their previous values; only a matching frame updates them.
- `DHT_CHECKSUM_EN` undefined: all five bytes are loaded on every complete frame and `error` reflects timeout only.

## Test plan
All scenarios use `CYCLES_PER_US`=2, `START_LOW_US`=20 and a bench sensor model.
- Valid frame 0x37,0x00,0x19,0x00,0x50 -> `done` pulse; `hum`=0x37, `tem`=0x19, `sum`=0x50, `error`=0; line low for 20 µs after `measure`.
- Sensor never answers -> `done` pulses 255 µs after release; `error`=1; data unchanged; `busy`=0.
- With `DHT_CHECKSUM_EN`, frame 0x37,0,0x19,0,0x51 -> `error`=1 and prior bytes held. Without the macro -> bytes load (`sum`=0x51) and `error`=0.
- Bit high pulses of 40 µs and 41 µs -> decode 0 and 1 respectively.
- Second `measure` during bit 10 -> ignored; frame completes normally with a single `done`.
- `reset` asserted during BIT_HIGH -> `onewire` released to Z; all outputs 0. A following `measure` yields a correct frame.
